// File: rtl/alu_pkg.sv
// Shared opcode and status-flag definitions for the alu_reg block.
package alu_pkg;

    // Opcode encoding as driven by the decoder
    typedef enum logic [3:0] {
        OP_ADD  = 4'd0,
        OP_SUB  = 4'd1,
        OP_AND  = 4'd2,
        OP_OR   = 4'd3,
        OP_XOR  = 4'd4,
        OP_NOT  = 4'd5,
        OP_NAND = 4'd6,
        OP_NOR  = 4'd7,
        OP_XNOR = 4'd8,
        OP_SHL  = 4'd9,
        OP_SHR  = 4'd10,
        OP_INC  = 4'd11,
        OP_DEC  = 4'd12,
        OP_ROL  = 4'd13,
        OP_ROR  = 4'd14,
        OP_PASS = 4'd15
    } alu_op_e;

    // Status flags produced alongside every result
    typedef struct packed {
        logic zero;
        logic carry;
        logic overflow;
        logic negative;
    } alu_flags_t;

endpackage

// File: rtl/alu_datapath.sv
// Combinational ALU core: result and flags from (x, y, sel), no state.
module alu_datapath
    import alu_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    input  logic [3:0]       sel,
    output logic [WIDTH-1:0] r,
    output alu_flags_t       flags
);

    localparam int MSB = WIDTH - 1;
    // Most positive / most negative two's complement values
    localparam logic [WIDTH-1:0] SMAX = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [WIDTH-1:0] SMIN = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [WIDTH-1:0] ONES = {WIDTH{1'b1}};
    localparam logic [WIDTH-1:0] ONE  = {{(WIDTH-1){1'b0}}, 1'b1};

    // One extra bit on the adders so the top bit is the carry / borrow
    logic [WIDTH:0] sum_full;
    logic [WIDTH:0] diff_full;

    assign sum_full  = {1'b0, x} + {1'b0, y};
    assign diff_full = {1'b0, x} - {1'b0, y};

    // Opcode decode; every path assigns result, carry and overflow
    always_comb begin
        r              = '0;
        flags.carry    = 1'b0;
        flags.overflow = 1'b0;
        unique case (alu_op_e'(sel))
            OP_ADD: begin
                r              = sum_full[MSB:0];
                flags.carry    = sum_full[WIDTH];
                flags.overflow = (x[MSB] == y[MSB]) && (sum_full[MSB] != x[MSB]);
            end
            OP_SUB: begin
                r              = diff_full[MSB:0];
                flags.carry    = diff_full[WIDTH];
                flags.overflow = (x[MSB] != y[MSB]) && (diff_full[MSB] != x[MSB]);
            end
            OP_AND:  r = x & y;
            OP_OR:   r = x | y;
            OP_XOR:  r = x ^ y;
            OP_NOT:  r = ~x;
            OP_NAND: r = ~(x & y);
            OP_NOR:  r = ~(x | y);
            OP_XNOR: r = ~(x ^ y);
            OP_SHL: begin
                r           = x << 1;
                flags.carry = x[MSB];
            end
            OP_SHR: begin
                r           = x >> 1;
                flags.carry = x[0];
            end
            OP_INC: begin
                r              = x + ONE;
                flags.carry    = (x == ONES);
                flags.overflow = (x == SMAX);
            end
            OP_DEC: begin
                r              = x - ONE;
                flags.carry    = (x == '0);
                flags.overflow = (x == SMIN);
            end
            OP_ROL: begin
                r           = {x[MSB-1:0], x[MSB]};
                flags.carry = x[MSB];
            end
            OP_ROR: begin
                r           = {x[0], x[MSB:1]};
                flags.carry = x[0];
            end
            OP_PASS: r = x;
        endcase
    end

    assign flags.zero     = (r == '0);
    assign flags.negative = r[MSB];

endmodule

// File: rtl/alu_reg.sv
// ALU with one output register stage: 1-cycle latency, one op per cycle.
module alu_reg
    import alu_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    input  logic [3:0]       sel,
    output logic [WIDTH-1:0] out,
    output logic             zero,
    output logic             carry,
    output logic             overflow,
    output logic             negative,
    output logic             out_valid
);

    logic [WIDTH-1:0] alu_r;
    alu_flags_t       alu_flags;

    logic [WIDTH-1:0] out_d,   out_q;
    alu_flags_t       flags_d, flags_q;
    logic             valid_d, valid_q;

    alu_datapath #(
        .WIDTH (WIDTH)
    ) u_datapath (
        .x     (x),
        .y     (y),
        .sel   (sel),
        .r     (alu_r),
        .flags (alu_flags)
    );

    // Capture a new result only on valid input; otherwise hold the last one
    always_comb begin
        out_d   = out_q;
        flags_d = flags_q;
        valid_d = in_valid;
        if (in_valid) begin
            out_d   = alu_r;
            flags_d = alu_flags;
        end
    end

    // Output register with synchronous reset taking priority over in_valid
    always_ff @(posedge clk) begin
        if (rst) begin
            out_q   <= '0;
            flags_q <= '0;
            valid_q <= 1'b0;
        end else begin
            out_q   <= out_d;
            flags_q <= flags_d;
            valid_q <= valid_d;
        end
    end

    assign out       = out_q;
    assign zero      = flags_q.zero;
    assign carry     = flags_q.carry;
    assign overflow  = flags_q.overflow;
    assign negative  = flags_q.negative;
    assign out_valid = valid_q;

endmodule

// File: tb/tb_alu_reg.sv
// Directed, table-driven bench for alu_reg plus reset / hold / back-to-back sequences.
module tb_alu_reg;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic [7:0] x, y;
    logic [3:0] sel;
    logic [7:0] out;
    logic       zero, carry, overflow, negative, out_valid;

    int checks = 0;
    int errors = 0;

    // Expected flags packed as {zero, carry, overflow, negative}
    typedef struct {
        logic [7:0] x;
        logic [7:0] y;
        logic [3:0] sel;
        logic [7:0] r;
        logic [3:0] f;
    } vec_t;

    vec_t vecs[$];

    alu_reg #(.WIDTH(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .x         (x),
        .y         (y),
        .sel       (sel),
        .out       (out),
        .zero      (zero),
        .carry     (carry),
        .overflow  (overflow),
        .negative  (negative),
        .out_valid (out_valid)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [3:0] cur_flags();
        return {zero, carry, overflow, negative};
    endfunction

    task automatic add_vec(input logic [7:0] vx, input logic [7:0] vy, input logic [3:0] vs,
                           input logic [7:0] vr, input logic [3:0] vf);
        vec_t v;
        v.x = vx; v.y = vy; v.sel = vs; v.r = vr; v.f = vf;
        vecs.push_back(v);
    endtask

    // Drive one operation at the falling edge and sample 1 time unit after the capture edge
    task automatic do_op(input logic v, input logic [7:0] vx, input logic [7:0] vy, input logic [3:0] vs);
        @(negedge clk);
        in_valid = v; x = vx; y = vy; sel = vs;
        @(posedge clk);
        #1;
    endtask

    logic [7:0] held_out;
    logic [3:0] held_f;

    initial begin
        //            x     y     sel   R     {Z,C,V,N}
        add_vec(8'd25,  8'd15,  4'd0,  8'd40,  4'b0000);
        add_vec(8'd25,  8'd15,  4'd1,  8'd10,  4'b0000);
        add_vec(8'd25,  8'd15,  4'd2,  8'd9,   4'b0000);
        add_vec(8'd25,  8'd15,  4'd3,  8'd31,  4'b0000);
        add_vec(8'd25,  8'd15,  4'd4,  8'd22,  4'b0000);
        add_vec(8'd25,  8'd15,  4'd5,  8'd230, 4'b0001);
        add_vec(8'd25,  8'd15,  4'd6,  8'd246, 4'b0001);
        add_vec(8'd25,  8'd15,  4'd7,  8'd224, 4'b0001);
        add_vec(8'd25,  8'd15,  4'd8,  8'd233, 4'b0001);
        add_vec(8'd25,  8'd15,  4'd9,  8'd50,  4'b0000);
        add_vec(8'd25,  8'd15,  4'd10, 8'd12,  4'b0100);
        add_vec(8'd25,  8'd15,  4'd11, 8'd26,  4'b0000);
        add_vec(8'd25,  8'd15,  4'd12, 8'd24,  4'b0000);
        add_vec(8'd25,  8'd15,  4'd13, 8'd50,  4'b0000);
        add_vec(8'd25,  8'd15,  4'd14, 8'd140, 4'b0101);
        add_vec(8'd25,  8'd15,  4'd15, 8'd25,  4'b0000);
        add_vec(8'd128, 8'd128, 4'd0,  8'd0,   4'b1110);
        add_vec(8'd128, 8'd128, 4'd1,  8'd0,   4'b1000);
        add_vec(8'd128, 8'd128, 4'd9,  8'd0,   4'b1100);
        add_vec(8'd127, 8'd0,   4'd11, 8'd128, 4'b0011);
        add_vec(8'd0,   8'd0,   4'd12, 8'd255, 4'b0101);
        add_vec(8'd128, 8'd0,   4'd13, 8'd1,   4'b0100);
        add_vec(8'd1,   8'd0,   4'd14, 8'd128, 4'b0101);
        add_vec(8'd255, 8'd0,   4'd11, 8'd0,   4'b1100);
        add_vec(8'd128, 8'd0,   4'd12, 8'd127, 4'b0010);
        add_vec(8'd0,   8'd1,   4'd1,  8'd255, 4'b0101);
        add_vec(8'd128, 8'd1,   4'd1,  8'd127, 4'b0010);
        add_vec(8'd127, 8'd1,   4'd0,  8'd128, 4'b0011);
        add_vec(8'd200, 8'd100, 4'd0,  8'd44,  4'b0100);

        rst = 1'b1; in_valid = 1'b1; x = 8'd25; y = 8'd15; sel = 4'd0;

        // Reset held for two cycles with a valid ADD present
        for (int i = 0; i < 2; i++) begin
            @(posedge clk); #1;
            check("reset_out", out, 8'd0);
            check("reset_flags", cur_flags(), 4'b0000);
            check("reset_valid", out_valid, 1'b0);
            $display("reset cycle %0d: out=%0d flags=%b valid=%b", i, out, cur_flags(), out_valid);
        end
        @(negedge clk); rst = 1'b0;
        @(posedge clk); #1;
        check("post_reset_out", out, 8'd40);
        check("post_reset_valid", out_valid, 1'b1);
        $display("after reset: out=%0d valid=%b", out, out_valid);

        // Table of single operations
        for (int i = 0; i < vecs.size(); i++) begin
            do_op(1'b1, vecs[i].x, vecs[i].y, vecs[i].sel);
            check($sformatf("vec%0d_out", i), out, vecs[i].r);
            check($sformatf("vec%0d_flags", i), cur_flags(), vecs[i].f);
            check($sformatf("vec%0d_valid", i), out_valid, 1'b1);
            $display("op x=%0d y=%0d sel=%0d -> out=%0d flags=%b (exp %0d %b)",
                     vecs[i].x, vecs[i].y, vecs[i].sel, out, cur_flags(), vecs[i].r, vecs[i].f);
        end

        // Hold: last op was 200+100 -> 44 with carry; in_valid low must freeze it
        held_out = 8'd44;
        held_f   = 4'b0100;
        for (int i = 0; i < 3; i++) begin
            do_op(1'b0, 8'(i * 37 + 3), 8'(i * 11), 4'(i + 5));
            check("hold_out", out, held_out);
            check("hold_flags", cur_flags(), held_f);
            check("hold_valid", out_valid, 1'b0);
            $display("hold cycle %0d: out=%0d flags=%b valid=%b", i, out, cur_flags(), out_valid);
        end

        // Back-to-back ADD then SUB on consecutive edges
        do_op(1'b1, 8'd25, 8'd15, 4'd0);
        check("b2b_add_out", out, 8'd40);
        check("b2b_add_valid", out_valid, 1'b1);
        $display("b2b ADD: out=%0d valid=%b", out, out_valid);
        x = 8'd25; y = 8'd15; sel = 4'd1;  // still before the next edge
        @(posedge clk); #1;
        check("b2b_sub_out", out, 8'd10);
        check("b2b_sub_valid", out_valid, 1'b1);
        $display("b2b SUB: out=%0d valid=%b", out, out_valid);

        // Reset with a non-zero negative result in the register
        do_op(1'b1, 8'd25, 8'd0, 4'd5);
        check("pre_rst_out", out, 8'd230);
        @(negedge clk); rst = 1'b1;
        @(posedge clk); #1;
        check("mid_rst_out", out, 8'd0);
        check("mid_rst_flags", cur_flags(), 4'b0000);
        check("mid_rst_valid", out_valid, 1'b0);
        $display("mid reset: out=%0d flags=%b valid=%b", out, cur_flags(), out_valid);
        @(negedge clk); rst = 1'b0; in_valid = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/alu_reg.md
Name: alu_reg

Overview:
- 8-bit, 16-opcode arithmetic/logic unit with registered result and four status flags (zero, carry, overflow, negative).
- Combinational datapath followed by one output register stage, giving 1-cycle latency.
- Sits in the execute stage of a small datapath and is driven by a 4-bit opcode from the decoder.

Parameters:
- WIDTH, 8, operand/result width; flags and shift rules below are written for the general WIDTH (MSB = bit WIDTH-1).

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  operands/opcode valid this cycle
- x  in  WIDTH  operand A
- y  in  WIDTH  operand B
- sel  in  4  opcode
- out  out  WIDTH  registered result
- zero  out  1  registered: out == 0
- carry  out  1  registered carry/borrow/shifted-out bit
- overflow  out  1  registered signed (two's complement) overflow
- negative  out  1  registered out[WIDTH-1]
- out_valid  out  1  registered in_valid

Behaviour:
- Reset: one clock, synchronous, active-high. When rst=1 at a rising edge, out, zero, carry, overflow, negative and out_valid all go to 0. rst overrides in_valid.
- Update rule:
  - in_valid=1 at an edge: the result and flags for (x, y, sel) are registered; out_valid=1 the next cycle.
  - in_valid=0: out and the flags hold their previous values; out_valid=0.
- Latency: exactly 1 cycle; a new operation can be accepted every cycle.
- Opcodes (R = result; carry C and overflow V are 0 unless stated):
  - 0 ADD: R = x+y; C = carry out of the MSB; V = both operands share a sign and R's sign differs.
  - 1 SUB: R = x-y; C = borrow (x<y unsigned); V = operand signs differ and R's sign differs from x.
  - 2 AND: R = x&y.
  - 3 OR: R = x|y.
  - 4 XOR: R = x^y.
  - 5 NOT: R = ~x.
  - 6 NAND: R = ~(x&y).
  - 7 NOR: R = ~(x|y).
  - 8 XNOR: R = ~(x^y).
  - 9 SHL: R = x<<1; C = x[MSB].
  - 10 SHR: R = x>>1 (logical); C = x[0].
  - 11 INC: R = x+1; C = (x==all-ones); V = (x==0x7F).
  - 12 DEC: R = x-1; C = borrow (x==0); V = (x==0x80).
  - 13 ROL: R = {x[MSB-1:0], x[MSB]}; C = x[MSB].
  - 14 ROR: R = {x[0], x[MSB:1]}; C = x[0].
  - 15 PASS: R = x.
- For all opcodes: zero = (R==0); negative = R[MSB].
- Arithmetic wraps modulo 2^WIDTH; there is no saturation.
- y is ignored for opcodes 5 and 9–15.
- The datapath is purely combinational from (x, y, sel) to the register D inputs. No latches: every opcode assigns every flag.

Decomposition:
- Shared package alu_pkg holds:
  - the opcode enum alu_op_e with values 0–15: OP_ADD … OP_PASS;
  - a flag struct alu_flags_t with fields zero, carry, overflow, negative.
- Sub-module alu_datapath: combinational; inputs x, y, sel; outputs R and alu_flags_t.
- alu_reg instantiates alu_datapath and adds the valid/reset register stage.

Test Plan:
- Reset: rst=1 for 2 cycles with in_valid=1, x=25, y=15, sel=0 -> out=0, all flags 0, out_valid=0. After rst drops, the next edge gives out=40.
- x=25, y=15, sel=0..4, in_valid=1 -> out = 40, 10, 9, 31, 22 one cycle later, with all flags 0.
- x=25, sel=5/9/10/11/12 -> out = 230 (negative=1), 50, 12 (C=1), 26, 24.
- x=128, y=128:
  - sel=0 -> out=0, zero=1, carry=1, overflow=1, negative=0.
  - sel=1 -> out=0, zero=1, carry=0, overflow=0.
  - sel=9 -> out=0, zero=1, carry=1.
- Boundaries:
  - x=127, sel=11 -> out=128, overflow=1, negative=1.
  - x=0, sel=12 -> out=255, carry=1.
  - x=128, sel=13 -> out=1, carry=1.
  - x=1, sel=14 -> out=128, carry=1.
- Hold and back-to-back:
  - in_valid=0 with changing x/y/sel -> out and flags unchanged, out_valid=0.
  - Back-to-back valid ops (ADD then SUB) -> results appear on consecutive cycles.
